// File: rtl/jk_bank_driver.sv
// rtl/jk_bank_driver.sv - J/K excitation controller for an external bank of JK flip-flops
//
// Accepts target state words over a valid/ready handshake, drives registered
// J/K excitation into a bank of WIDTH JK flip-flops sharing this clock, then
// reads the bank's Q outputs back and flags any bit that missed its target.
//
// Ports:
//   clk       - single clock, all logic on the rising edge
//   rst       - synchronous active-high reset
//   tgt_valid - target word valid
//   tgt_data  - requested next bank state
//   tgt_ready - driver can accept a target (IDLE only)
//   j_out     - J inputs to the bank
//   k_out     - K inputs to the bank
//   q_in      - Q outputs fed back from the bank
//   q_shadow  - driver's model of the bank state
//   done      - one-cycle pulse when a target check completes
//   mismatch  - one-cycle pulse with done when q_in != q_shadow
//   err_flag  - sticky error, set by any mismatch (including the init check)
//   clr_err   - clears err_flag; a simultaneous new mismatch wins
module jk_bank_driver #(
   parameter int WIDTH       = 4,
   parameter int TOGGLE_PREF = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tgt_valid,
   input  logic [WIDTH-1:0] tgt_data,
   output logic             tgt_ready,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] q_shadow,
   output logic             done,
   output logic             mismatch,
   output logic             err_flag,
   input  logic             clr_err
);

   localparam logic [2:0] S_INIT     = 3'd0;
   localparam logic [2:0] S_INIT_CHK = 3'd1;
   localparam logic [2:0] S_IDLE     = 3'd2;
   localparam logic [2:0] S_DRIVE    = 3'd3;
   localparam logic [2:0] S_CHECK    = 3'd4;

   logic [2:0]       state;
   logic [WIDTH-1:0] j_q;
   logic [WIDTH-1:0] k_q;
   logic [WIDTH-1:0] shadow_q;
   logic             err_q;
   logic [WIDTH-1:0] change;
   logic [WIDTH-1:0] j_next;
   logic [WIDTH-1:0] k_next;
   logic             chk_fail;
   logic             force_zero;

   // Bits that must move from the current shadow to the requested target.
   assign change = shadow_q ^ tgt_data;

   always_comb begin
      j_next = '0;
      k_next = '0;
      if (TOGGLE_PREF != 0) begin
         j_next = change;
         k_next = change;
      end else begin
         // 0->1 sets, 1->0 resets; unchanged bits hold with 00.
         j_next = change & tgt_data;
         k_next = change & shadow_q;
      end
   end

   // Init check expects an all-zero bank; the target check expects the shadow.
   assign chk_fail = ((state == S_INIT_CHK) && (q_in != '0)) ||
                     ((state == S_CHECK)    && (q_in != shadow_q));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_INIT;
         j_q      <= '0;
         k_q      <= '0;
         shadow_q <= '0;
         err_q    <= 1'b0;
      end else begin
         // Excitation is live for exactly one cycle (DRIVE); every other
         // state returns J/K to hold.
         j_q <= '0;
         k_q <= '0;
         case (state)
            S_INIT:     state <= S_INIT_CHK;
            S_INIT_CHK: state <= S_IDLE;
            S_IDLE: begin
               if (tgt_valid) begin
                  j_q      <= j_next;
                  k_q      <= k_next;
                  shadow_q <= tgt_data;
                  state    <= S_DRIVE;
               end
            end
            S_DRIVE:    state <= S_CHECK;
            S_CHECK:    state <= S_IDLE;
            default:    state <= S_INIT;
         endcase
         if (chk_fail) begin
            err_q <= 1'b1;
         end else if (clr_err) begin
            err_q <= 1'b0;
         end
      end
   end

   // The force-to-zero pattern is presented only once reset has been released,
   // so the bank sees hold while reset is held and the clear lands on the edge
   // that ends INIT.
   assign force_zero = (state == S_INIT) && !rst;

   assign tgt_ready = (state == S_IDLE);
   assign j_out     = j_q;
   assign k_out     = k_q | {WIDTH{force_zero}};
   assign q_shadow  = shadow_q;
   assign done      = (state == S_CHECK);
   assign mismatch  = (state == S_CHECK) && (q_in != shadow_q);
   assign err_flag  = err_q;

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Control-side counterpart of the team's JK flip-flop: a controller that drives J/K inputs, not another flip-flop.
- Accepts target state words over a valid/ready handshake and computes per-bit J/K excitation for an external bank of WIDTH JK flip-flops on the same clock.
- Reads the bank's Q outputs back and checks that each target was reached.
- Sits between a pattern source (sequencer or CPU register) and the JK register bank.

Parameters:
- WIDTH, 4, number of JK flip-flops in the driven bank (1..32).
- TOGGLE_PREF, 0, 0 = minimal excitation (changes use J/K = 10 or 01); 1 = changes use J/K = 11 (toggle).

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high (sampled on posedge clk).
- tgt_valid  input  1  target word valid.
- tgt_data  input  WIDTH  requested next bank state.
- tgt_ready  output  1  driver can accept a target.
- j_out  output  WIDTH  J inputs to bank; registered.
- k_out  output  WIDTH  K inputs to bank; registered.
- q_in  input  WIDTH  Q outputs fed back from bank.
- q_shadow  output  WIDTH  driver's model of bank state.
- done  output  1  one-cycle pulse when a check completes.
- mismatch  output  1  one-cycle pulse with done when q_in != q_shadow.
- err_flag  output  1  sticky error; set by any mismatch.
- clr_err  input  1  clears err_flag.

Behaviour:
- Reset values: tgt_ready=0, j_out=0, k_out=0, q_shadow=0, done=0, mismatch=0, err_flag=0. FSM goes to INIT.
- Reset asserted mid-operation aborts the current target; no done pulse is issued for it.
- FSM states: INIT, INIT_CHK, IDLE, DRIVE, CHECK.
- INIT (1 cycle): j_out=0, k_out=all ones, which forces the bank to 0. Next state INIT_CHK.
- INIT_CHK (1 cycle): j_out=k_out=0. Compare q_in to 0; on mismatch set err_flag; no done pulse. Next state IDLE.
- IDLE: tgt_ready=1; j_out=k_out=0, so the bank holds.
  - On tgt_valid & tgt_ready, compute excitation per bit i from q_shadow[i] and tgt_data[i], register it into j_out/k_out, set q_shadow<=tgt_data, and go to DRIVE.
- Excitation with TOGGLE_PREF=0:
  - 0->0: J=0, K=0
  - 0->1: J=1, K=0
  - 1->0: J=0, K=1
  - 1->1: J=0, K=0
- Excitation with TOGGLE_PREF=1: any bit that changes gets J=K=1; unchanged bits get 00.
- DRIVE (1 cycle): j_out/k_out are stable and tgt_ready=0. The bank samples at the end of this cycle. Next state CHECK; j_out/k_out return to 0 on entering CHECK.
- CHECK (1 cycle):
  - Compare q_in with q_shadow; done=1.
  - On inequality, mismatch=1 and err_flag<=1.
  - Next state IDLE.
- Latency: handshake accepted at cycle T, J/K active in T+1, done in T+2, tgt_ready high again at T+3. Maximum throughput is one target per 3 cycles.
- A target equal to q_shadow is still fully processed: J=K=0 in DRIVE, done in CHECK.
- tgt_data is sampled only on the accepting cycle; later changes are ignored.
- clr_err clears err_flag the next cycle. If it coincides with a mismatch in the same cycle, the set wins and err_flag stays 1.
- J=K=1 is never driven in INIT, IDLE, or CHECK.
- q_shadow changes only on accept or reset.

Test Plan:
- Reset for 2 cycles, bank model correct: INIT drives k_out=4'hF, j_out=0. err_flag stays 0, tgt_ready rises 2 cycles after reset deasserts, no done pulse.
- TOGGLE_PREF=0, shadow 4'b0000, target 4'b1010: DRIVE shows j_out=4'b1010, k_out=0. Next, target 4'b0110: j_out=4'b0100, k_out=4'b1000. Each gives done=1, mismatch=0, q_shadow as targeted.
- TOGGLE_PREF=1, shadow 4'b1010, target 4'b0110: j_out=k_out=4'b1100; bank reaches 4'b0110; no mismatch.
- Back-to-back valid held high with targets 1, 2, 3: accepts spaced exactly 3 cycles apart, three done pulses, each target sampled only at its accept.
- Bank model with bit 2 stuck at 0, target 4'b0100: CHECK gives done=1, mismatch=1, err_flag=1.
  - clr_err with no new error clears err_flag.
  - clr_err in the same cycle as a new mismatch leaves err_flag=1.
- rst asserted during DRIVE: next cycle j_out=0, k_out=0, q_shadow=0, no done; the INIT sequence replays.
